// File: rtl/aspiradora_cmd_if.sv
// Command handshake between the switch conditioner (master) and the aspiradora FSM (slave).
// cmd is one-hot with the same bit map as the raw switches, and zero while cmd_valid is low.
interface aspiradora_cmd_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd;

   modport master (output cmd_valid, output cmd, input cmd_ready);
   modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/aspiradora_cmd_conditioner.sv
// Synchronises, debounces and edge-detects four board switches into queued one-hot requests,
// then offers them over a valid/ready handshake, one at a time, highest priority first.
module aspiradora_cmd_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       sw_raw,
   aspiradora_cmd_if.master cmd_if,
   output logic [3:0]       sw_level,
   output logic             overrun
);
   typedef enum logic {IDLE, OFFER} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
   logic [3:0]       level_q, level_d, level_prev_q, level_prev_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       pending_q, pending_d;
   logic [3:0]       cmd_q, cmd_d;
   logic             overrun_q, overrun_d;
   state_t           state_q, state_d;
   logic [3:0]       rise, clr;
   logic             flush;

   always_comb begin
      sync1_d      = sw_raw;
      sync2_d      = sync1_q;
      level_d      = level_q;
      level_prev_d = level_q;
      for (int unsigned i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) level_d[i] = sync2_q[i];
            else                      cnt_d[i]   = cnt_q[i] + 1'b1;
         end
      end
   end

   // A pending power_off flushes every other request, including rises landing this cycle.
   always_comb begin
      rise      = level_q & ~level_prev_q;
      clr       = (state_q == OFFER && cmd_if.cmd_ready) ? cmd_q : '0;
      flush     = pending_q[0] | rise[0];
      pending_d = (pending_q & ~clr) | rise;
      overrun_d = overrun_q | (|(rise & pending_q & ~clr & {~{3{flush}}, 1'b1}));
      if (flush) pending_d[3:1] = '0;
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               state_d = OFFER;
               if      (pending_q[0]) cmd_d = 4'b0001;
               else if (pending_q[3]) cmd_d = 4'b1000;
               else if (pending_q[2]) cmd_d = 4'b0100;
               else                   cmd_d = 4'b0010;
            end
         end
         OFFER: begin
            if (cmd_if.cmd_ready) begin
               state_d = IDLE;
               cmd_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         cnt_q        <= '{default: '0};
         pending_q    <= '0;
         cmd_q        <= '0;
         overrun_q    <= 1'b0;
         state_q      <= IDLE;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         cmd_q        <= cmd_d;
         overrun_q    <= overrun_d;
         state_q      <= state_d;
      end
   end

   assign cmd_if.cmd_valid = (state_q == OFFER);
   assign cmd_if.cmd       = cmd_q;
   assign sw_level         = level_q;
   assign overrun          = overrun_q;
endmodule

// File: tb/tb_aspiradora_cmd_conditioner.sv
// Bench for aspiradora_cmd_conditioner: reset vector table, directed corner sequences,
// and random switch/ready traffic against a sample-history reference model.
module tb_aspiradora_cmd_conditioner;
   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sw_raw;
   logic [3:0] sw_level;
   logic       overrun;

   aspiradora_cmd_if cmd_if ();

   aspiradora_cmd_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw),
      .cmd_if   (cmd_if),
      .sw_level (sw_level),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] acc [$];

   typedef struct {
      logic       rst_n;
      logic [3:0] raw;
      logic       rdy;
      logic       e_valid;
      logic [3:0] e_cmd;
      logic [3:0] e_level;
      logic       e_ov;
   } vec_t;
   vec_t tbl [13];

   // Reference model: raw sample history, pending set, current offer (-1 when none).
   bit [3:0] m_hist [0:DC];
   bit [3:0] m_level = '0, m_prev = '0, m_pend = '0;
   bit       m_ov = 1'b0;
   int       m_offer = -1;

   function automatic int pick(bit [3:0] p);
      if (p[0]) return 0;
      if (p[3]) return 3;
      if (p[2]) return 2;
      if (p[1]) return 1;
      return -1;
   endfunction

   task automatic model_edge(input logic r, input logic [3:0] raw, input logic rdy);
      bit [3:0] rise, nl, np;
      bit       flush, cleared, all_diff;
      int       no;
      if (!r) begin
         for (int k = 0; k <= DC; k++) m_hist[k] = '0;
         m_level = '0; m_prev = '0; m_pend = '0; m_ov = 1'b0; m_offer = -1;
         return;
      end
      rise  = m_level & ~m_prev;
      flush = m_pend[0] || rise[0];
      np    = m_pend;
      for (int i = 0; i < 4; i++) begin
         cleared = (m_offer == i) && rdy;
         if (i > 0 && flush) np[i] = 1'b0;
         else if (rise[i]) begin
            if (m_pend[i] && !cleared) m_ov = 1'b1;
            np[i] = 1'b1;
         end else if (cleared) np[i] = 1'b0;
      end
      if (m_offer >= 0) no = rdy ? -1 : m_offer;
      else              no = pick(m_pend);
      nl = m_level;
      for (int i = 0; i < 4; i++) begin
         all_diff = 1'b1;
         for (int k = 1; k <= DC; k++) if (m_hist[k][i] == m_level[i]) all_diff = 1'b0;
         if (all_diff) nl[i] = ~m_level[i];
      end
      for (int k = DC; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = raw;
      m_prev  = m_level;
      m_level = nl;
      m_pend  = np;
      m_offer = no;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] raw, input logic rdy);
      logic [3:0] e_cmd;
      rst_n = r; sw_raw = raw; cmd_if.cmd_ready = rdy;
      if (cmd_if.cmd_valid === 1'b1 && rdy && r) acc.push_back(cmd_if.cmd);
      @(posedge clk);
      model_edge(r, raw, rdy);
      #1;
      e_cmd = (m_offer >= 0) ? 4'(1 << m_offer) : 4'h0;
      chk("model_valid",   32'(cmd_if.cmd_valid), 32'(m_offer >= 0));
      chk("model_cmd",     32'(cmd_if.cmd),       32'(e_cmd));
      chk("model_level",   32'(sw_level),         32'(m_level));
      chk("model_overrun", 32'(overrun),          32'(m_ov));
   endtask

   task automatic do_reset();
      step(1'b0, 4'h0, 1'b0);
      step(1'b0, 4'h0, 1'b0);
      acc.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] raw;
      logic       rdy, r;

      for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
      for (int i = 3; i < 8; i++) tbl[i] = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
      tbl[8]  = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0};
      tbl[9]  = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0};
      tbl[10] = '{1'b1, 4'hF, 1'b1, 1'b1, 4'h1, 4'hF, 1'b0};
      tbl[11] = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0};
      tbl[12] = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0};

      // Reset with all switches on, then power_off flush on release.
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].rst_n, tbl[i].raw, tbl[i].rdy);
         chk("tbl_valid",   32'(cmd_if.cmd_valid), 32'(tbl[i].e_valid));
         chk("tbl_cmd",     32'(cmd_if.cmd),       32'(tbl[i].e_cmd));
         chk("tbl_level",   32'(sw_level),         32'(tbl[i].e_level));
         chk("tbl_overrun", 32'(overrun),          32'(tbl[i].e_ov));
      end
      for (int i = 0; i < 8; i++) step(1'b1, 4'hF, 1'b1);
      chk("flush_cmd_count", 32'(acc.size()), 32'd1);
      if (acc.size() > 0) chk("flush_cmd", 32'(acc[0]), 32'h1);

      // Bouncing on switch, then stable: exactly one command.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
      for (int i = 0; i < 15; i++) step(1'b1, 4'b0010, 1'b1);
      chk("bounce_cmd_count", 32'(acc.size()), 32'd1);
      if (acc.size() > 0) chk("bounce_cmd", 32'(acc[0]), 32'h2);
      for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 1'b1);
      acc.delete();
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 4'b0000, 1'b1);
         chk("glitch_level", 32'(sw_level[1]), 32'd0);
      end
      chk("glitch_cmd_count", 32'(acc.size()), 32'd0);

      // Offer held stable while the FSM stalls, released by one ready.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 4'b0010, 1'b0);
         if (i >= 9) begin
            chk("stall_valid", 32'(cmd_if.cmd_valid), 32'd1);
            chk("stall_cmd",   32'(cmd_if.cmd),       32'h2);
         end
      end
      step(1'b1, 4'b0010, 1'b1);
      chk("accept_valid_drop", 32'(cmd_if.cmd_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'b0010, 1'b0);
         chk("accept_no_reoffer", 32'(cmd_if.cmd_valid), 32'd0);
      end

      // Three simultaneous rises drain in priority order.
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 4'b1110, 1'b1);
      chk("prio_count", 32'(acc.size()), 32'd3);
      if (acc.size() == 3) begin
         chk("prio_0", 32'(acc[0]), 32'h8);
         chk("prio_1", 32'(acc[1]), 32'h4);
         chk("prio_2", 32'(acc[2]), 32'h2);
      end

      // Power_off flushes a pending cleaning request behind a stalled on offer.
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b1, 4'b0010, 1'b0);
      for (int i = 0; i < 8; i++)  step(1'b1, 4'b0110, 1'b0);
      for (int i = 0; i < 8; i++)  step(1'b1, 4'b0111, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 4'b0111, 1'b1);
      chk("flush_seq_count", 32'(acc.size()), 32'd2);
      if (acc.size() == 2) begin
         chk("flush_seq_0", 32'(acc[0]), 32'h2);
         chk("flush_seq_1", 32'(acc[1]), 32'h1);
      end
      chk("flush_no_overrun", 32'(overrun), 32'd0);

      // Second on rise while still pending sets the sticky overrun flag.
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b1, 4'b0010, 1'b0);
      for (int i = 0; i < 8; i++)  step(1'b1, 4'b0000, 1'b0);
      chk("overrun_before", 32'(overrun), 32'd0);
      for (int i = 0; i < 8; i++)  step(1'b1, 4'b0010, 1'b0);
      chk("overrun_set", 32'(overrun), 32'd1);
      for (int i = 0; i < 6; i++)  step(1'b1, 4'b0000, 1'b1);
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // Reset during an offer drops it and clears pending.
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b1, 4'b0010, 1'b0);
      chk("midrst_offer", 32'(cmd_if.cmd_valid), 32'd1);
      step(1'b0, 4'b0000, 1'b0);
      chk("midrst_valid", 32'(cmd_if.cmd_valid), 32'd0);
      chk("midrst_cmd",   32'(cmd_if.cmd),       32'h0);
      acc.delete();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'b0000, 1'b1);
         chk("midrst_idle", 32'(cmd_if.cmd_valid), 32'd0);
      end
      chk("midrst_no_cmd", 32'(acc.size()), 32'd0);

      // Random switch activity, stalls and occasional resets.
      do_reset();
      raw = '0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(7) == 0) raw = raw ^ 4'(1 << $urandom_range(3));
         rdy = 1'($urandom_range(1));
         r   = ($urandom_range(399) != 0);
         step(r, raw, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
